// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID codes, PID class decode, CRC constants and decoder FSM encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        CLS_TOKEN,
        CLS_DATA,
        CLS_HS,
        CLS_SPECIAL
    } pid_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOK,
        ST_DATA,
        ST_HS,
        ST_WAIT_END
    } state_t;

    function automatic pid_class_t pid_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:         return CLS_TOKEN;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:  return CLS_DATA;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:       return CLS_HS;
            default:                                     return CLS_SPECIAL;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// rtl/usb_crc16_byte.sv - combinational CRC16 (x^16+x^15+x^2+1) update over one byte, LSB first.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    always_comb begin
        logic [15:0] c;
        c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (i_data[i] ^ c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                   c = {c[14:0], 1'b0};
        end
        o_crc = c;
    end

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// rtl/usb_rx_pkt_decoder.sv - UTMI receive packet decoder: PID, token/CRC5, data/CRC16, handshakes.
// Optional SOF output ports (sof_valid_o, frame_no_o) are enabled by defining USB_RX_SOF_EN.
module usb_rx_pkt_decoder
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1023,
    parameter int CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_active_i,
    input  logic        rx_err_i,
    output logic [3:0]  pid_o,
    output logic        tok_valid_o,
    output logic [6:0]  tok_addr_o,
    output logic [3:0]  tok_ep_o,
`ifdef USB_RX_SOF_EN
    output logic        sof_valid_o,
    output logic [10:0] frame_no_o,
`endif
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        data_done_o,
    output logic        crc16_err_o,
    output logic        hs_valid_o,
    output logic        pid_err_o,
    output logic        crc5_err_o,
    output logic        seq_err_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_crc5;
    logic [15:0]      r_crc16;
    logic [7:0]       r_b0;
    logic [7:0]       r_b1;
    logic             r_fresh;
    logic             r_is_sof;

    logic             w_abort;
    logic             w_byte;
    logic             w_ovf;
    logic [4:0]       w_crc5_upd;
    logic [15:0]      w_crc16_upd;
    logic [4:0]       w_crc5_nxt;
    logic [15:0]      w_crc16_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_tb1;
    logic [2:0]       w_tb2_lo;

    usb_crc16_byte u_crc16 (
        .i_crc  (r_crc16),
        .i_data (rx_data_i),
        .o_crc  (w_crc16_upd)
    );

    // Next-cycle view of counters/CRCs so a byte coinciding with EOP is folded in first.
    always_comb begin
        w_abort  = rx_active_i && rx_err_i;
        w_byte   = rx_valid_i && !w_abort &&
                   (r_state == ST_TOK || r_state == ST_DATA || r_state == ST_HS);
        w_ovf    = w_byte && (r_state == ST_DATA) && (r_cnt == CNT_W'(MAX_PAYLOAD + 2));

        w_crc5_upd = r_crc5;
        for (int i = 0; i < 8; i++) begin
            if (rx_data_i[i] ^ w_crc5_upd[4]) w_crc5_upd = {w_crc5_upd[3:0], 1'b0} ^ CRC5_POLY;
            else                              w_crc5_upd = {w_crc5_upd[3:0], 1'b0};
        end

        w_crc5_nxt  = w_byte ? w_crc5_upd  : r_crc5;
        w_crc16_nxt = w_byte ? w_crc16_upd : r_crc16;
        w_cnt_nxt   = r_cnt;
        if (w_byte && (r_state == ST_DATA || r_cnt < CNT_W'(3)))
            w_cnt_nxt = r_cnt + 1'b1;
        w_tb1    = (w_byte && r_cnt == CNT_W'(0)) ? rx_data_i      : r_b0;
        w_tb2_lo = (w_byte && r_cnt == CNT_W'(1)) ? rx_data_i[2:0] : r_b1[2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_crc5       <= CRC5_INIT;
            r_crc16      <= CRC16_INIT;
            r_b0         <= '0;
            r_b1         <= '0;
            r_fresh      <= 1'b1;
            r_is_sof     <= 1'b0;
            pid_o        <= '0;
            tok_valid_o  <= 1'b0;
            tok_addr_o   <= '0;
            tok_ep_o     <= '0;
`ifdef USB_RX_SOF_EN
            sof_valid_o  <= 1'b0;
            frame_no_o   <= '0;
`endif
            data_o       <= '0;
            data_valid_o <= 1'b0;
            data_done_o  <= 1'b0;
            crc16_err_o  <= 1'b0;
            hs_valid_o   <= 1'b0;
            pid_err_o    <= 1'b0;
            crc5_err_o   <= 1'b0;
            seq_err_o    <= 1'b0;
        end else begin
            r_fresh      <= 1'b0;
            tok_valid_o  <= 1'b0;
`ifdef USB_RX_SOF_EN
            sof_valid_o  <= 1'b0;
`endif
            data_valid_o <= 1'b0;
            data_done_o  <= 1'b0;
            crc16_err_o  <= 1'b0;
            hs_valid_o   <= 1'b0;
            pid_err_o    <= 1'b0;
            crc5_err_o   <= 1'b0;
            seq_err_o    <= 1'b0;

            r_cnt   <= w_cnt_nxt;
            r_crc5  <= w_crc5_nxt;
            r_crc16 <= w_crc16_nxt;
            if (w_byte && r_cnt == CNT_W'(0)) r_b0 <= rx_data_i;
            if (w_byte && r_cnt == CNT_W'(1)) r_b1 <= rx_data_i;
            // Two-byte skid: the last two bytes are the CRC16 and never reach data_o.
            if (w_byte && r_state == ST_DATA && r_cnt >= CNT_W'(2) && !w_ovf) begin
                data_o       <= r_b0;
                data_valid_o <= 1'b1;
                r_b0         <= r_b1;
                r_b1         <= rx_data_i;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_crc5  <= CRC5_INIT;
                    r_crc16 <= CRC16_INIT;
                    if (rx_active_i) r_state <= r_fresh ? ST_WAIT_END : ST_PID;
                end
                ST_PID: begin
                    r_cnt   <= '0;
                    r_crc5  <= CRC5_INIT;
                    r_crc16 <= CRC16_INIT;
                    if (w_abort) begin
                        seq_err_o <= 1'b1;
                        r_state   <= ST_WAIT_END;
                    end else if (rx_valid_i) begin
                        pid_o    <= rx_data_i[3:0];
                        r_is_sof <= (rx_data_i[3:0] == PID_SOF);
                        if (rx_data_i[7:4] != ~rx_data_i[3:0]) begin
                            pid_err_o <= 1'b1;
                            r_state   <= ST_WAIT_END;
                        end else begin
                            case (pid_class(rx_data_i[3:0]))
                                CLS_TOKEN: r_state <= ST_TOK;
                                CLS_DATA:  r_state <= ST_DATA;
                                CLS_HS:    r_state <= ST_HS;
                                default:   r_state <= ST_WAIT_END;
                            endcase
                        end
                    end else if (!rx_active_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_TOK: begin
                    if (w_abort) begin
                        seq_err_o <= 1'b1;
                        r_state   <= ST_WAIT_END;
                    end else if (!rx_active_i) begin
                        r_state <= ST_IDLE;
                        if (w_cnt_nxt != CNT_W'(2)) begin
                            seq_err_o <= 1'b1;
                        end else if (w_crc5_nxt != CRC5_RESIDUAL) begin
                            crc5_err_o <= 1'b1;
                        end else if (r_is_sof) begin
`ifdef USB_RX_SOF_EN
                            sof_valid_o <= 1'b1;
                            frame_no_o  <= {w_tb2_lo, w_tb1};
`endif
                        end else begin
                            tok_valid_o <= 1'b1;
                            tok_addr_o  <= w_tb1[6:0];
                            tok_ep_o    <= {w_tb2_lo, w_tb1[7]};
                        end
                    end
                end
                ST_DATA: begin
                    if (w_abort || w_ovf) begin
                        seq_err_o   <= 1'b1;
                        data_done_o <= 1'b1;
                        crc16_err_o <= 1'b1;
                        r_state     <= ST_WAIT_END;
                    end else if (!rx_active_i) begin
                        data_done_o <= 1'b1;
                        crc16_err_o <= (w_crc16_nxt != CRC16_RESIDUAL) || (w_cnt_nxt < CNT_W'(2));
                        r_state     <= ST_IDLE;
                    end
                end
                ST_HS: begin
                    if (w_abort) begin
                        seq_err_o <= 1'b1;
                        r_state   <= ST_WAIT_END;
                    end else if (!rx_active_i) begin
                        if (w_cnt_nxt == CNT_W'(0)) hs_valid_o <= 1'b1;
                        else                        seq_err_o  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_END: begin
                    if (!rx_active_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// tb/tb_usb_rx_pkt_decoder.sv - directed self-checking bench for usb_rx_pkt_decoder.
module tb_usb_rx_pkt_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_active_i;
    logic        rx_err_i;
    logic [3:0]  pid_o;
    logic        tok_valid_o;
    logic [6:0]  tok_addr_o;
    logic [3:0]  tok_ep_o;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_done_o;
    logic        crc16_err_o;
    logic        hs_valid_o;
    logic        pid_err_o;
    logic        crc5_err_o;
    logic        seq_err_o;
`ifdef USB_RX_SOF_EN
    logic        sof_valid_o;
    logic [10:0] frame_no_o;
`endif

    always #5 clk = ~clk;

    usb_rx_pkt_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_active_i  (rx_active_i),
        .rx_err_i     (rx_err_i),
        .pid_o        (pid_o),
        .tok_valid_o  (tok_valid_o),
        .tok_addr_o   (tok_addr_o),
        .tok_ep_o     (tok_ep_o),
`ifdef USB_RX_SOF_EN
        .sof_valid_o  (sof_valid_o),
        .frame_no_o   (frame_no_o),
`endif
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_done_o  (data_done_o),
        .crc16_err_o  (crc16_err_o),
        .hs_valid_o   (hs_valid_o),
        .pid_err_o    (pid_err_o),
        .crc5_err_o   (crc5_err_o),
        .seq_err_o    (seq_err_o)
    );

    int passed = 0;
    int total  = 0;

    int n_tok = 0, n_dv = 0, n_done = 0, n_done_err = 0, n_hs = 0;
    int n_pe = 0, n_c5 = 0, n_seq = 0, n_sof = 0;
    logic [7:0] dq[$];
    logic [10:0] last_frame = '0;

    always @(negedge clk) begin
        if (tok_valid_o)  n_tok++;
        if (data_valid_o) begin n_dv++; dq.push_back(data_o); end
        if (data_done_o)  begin n_done++; if (crc16_err_o) n_done_err++; end
        if (hs_valid_o)   n_hs++;
        if (pid_err_o)    n_pe++;
        if (crc5_err_o)   n_c5++;
        if (seq_err_o)    n_seq++;
`ifdef USB_RX_SOF_EN
        if (sof_valid_o)  begin n_sof++; last_frame = frame_no_o; end
`endif
    end

    int s_tok, s_dv, s_done, s_done_err, s_hs, s_pe, s_c5, s_seq, s_sof;
    logic [7:0] pkt[$];

    task automatic snap();
        s_tok = n_tok; s_dv = n_dv; s_done = n_done; s_done_err = n_done_err; s_hs = n_hs;
        s_pe = n_pe; s_c5 = n_c5; s_seq = n_seq; s_sof = n_sof;
    endtask

    task automatic start_pkt();
        @(posedge clk); #1 rx_active_i = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_bytes();
        foreach (pkt[i]) begin
            @(posedge clk); #1 rx_data_i = pkt[i]; rx_valid_i = 1'b1;
            @(posedge clk); #1 rx_valid_i = 1'b0;
        end
    endtask

    // Drops RxActive, then returns #1 after the edge on which the end-of-packet pulses appear.
    task automatic end_pkt();
        @(posedge clk); #1 rx_active_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0; rx_active_i = 1'b0; rx_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pid_o, tok_valid_o, tok_addr_o, tok_ep_o, data_o, data_valid_o, data_done_o,
             crc16_err_o, hs_valid_o, pid_err_o, crc5_err_o, seq_err_o} !== 34'h0)
            $display("FAIL reset_outputs: got pid=%h tok=%b data=%h dv=%b done=%b required all 0",
                     pid_o, tok_valid_o, data_o, data_valid_o, data_done_o);
        else passed++;
        rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_token();
        snap();
        pkt = '{8'h2D, 8'h00, 8'h10};
        start_pkt(); send_bytes(); end_pkt();
        total++;
        if (tok_valid_o !== 1'b1) $display("FAIL setup_tok_latency: got %b required 1", tok_valid_o);
        else passed++;
        total++;
        if ({tok_addr_o, tok_ep_o} !== 11'h000) $display("FAIL setup_addr_ep: got addr=%h ep=%h required 0/0", tok_addr_o, tok_ep_o);
        else passed++;
        total++;
        if (pid_o !== 4'hD) $display("FAIL setup_pid: got %h required D", pid_o);
        else passed++;
        settle();
        total++;
        if (n_tok - s_tok != 1 || (n_pe - s_pe) + (n_c5 - s_c5) + (n_seq - s_seq) != 0)
            $display("FAIL setup_counts: got tok=%0d err=%0d required 1/0", n_tok - s_tok,
                     (n_pe - s_pe) + (n_c5 - s_c5) + (n_seq - s_seq));
        else passed++;

        pkt = '{8'h69, 8'h01, 8'hE8};
        start_pkt(); send_bytes(); end_pkt();
        total++;
        if (tok_valid_o !== 1'b1 || tok_addr_o !== 7'h01 || tok_ep_o !== 4'h0)
            $display("FAIL in_addr1: got tok=%b addr=%h ep=%h required 1/01/0", tok_valid_o, tok_addr_o, tok_ep_o);
        else passed++;
        settle();

        pkt = '{8'hE1, 8'h80, 8'hA0};
        start_pkt(); send_bytes(); end_pkt();
        total++;
        if (tok_valid_o !== 1'b1 || tok_addr_o !== 7'h00 || tok_ep_o !== 4'h1 || pid_o !== 4'h1)
            $display("FAIL out_ep1: got tok=%b addr=%h ep=%h pid=%h required 1/00/1/1", tok_valid_o, tok_addr_o, tok_ep_o, pid_o);
        else passed++;
        settle();
    endtask

    task automatic test_data();
        logic [63:0] got;
        int base;
        snap();
        base = dq.size();
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        start_pkt(); send_bytes(); end_pkt();
        total++;
        if (data_done_o !== 1'b1 || crc16_err_o !== 1'b0)
            $display("FAIL data0_done: got done=%b err=%b required 1/0", data_done_o, crc16_err_o);
        else passed++;
        settle();
        total++;
        if (n_dv - s_dv != 8) $display("FAIL data0_count: got %0d required 8", n_dv - s_dv);
        else passed++;
        got = '0;
        for (int i = 0; i < 8; i++)
            if (base + i < dq.size()) got = {got[55:0], dq[base + i]};
        total++;
        if (got !== 64'h8006000100004000) $display("FAIL data0_bytes: got %h required 8006000100004000", got);
        else passed++;
        total++;
        if (n_done - s_done != 1 || n_seq - s_seq != 0 || pid_o !== 4'h3)
            $display("FAIL data0_misc: got done=%0d seq=%0d pid=%h required 1/0/3", n_done - s_done, n_seq - s_seq, pid_o);
        else passed++;
    endtask

    task automatic test_short_data();
        snap();
        pkt = '{8'h4B, 8'h00, 8'h00};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_done - s_done != 1 || n_done_err - s_done_err != 0 || n_dv - s_dv != 0)
            $display("FAIL zlp: got done=%0d err=%0d dv=%0d required 1/0/0", n_done - s_done, n_done_err - s_done_err, n_dv - s_dv);
        else passed++;
        snap();
        pkt = '{8'hC3, 8'hAA};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_done - s_done != 1 || n_done_err - s_done_err != 1 || n_dv - s_dv != 0)
            $display("FAIL one_byte_data: got done=%0d err=%0d dv=%0d required 1/1/0", n_done - s_done, n_done_err - s_done_err, n_dv - s_dv);
        else passed++;
    endtask

    task automatic test_handshake();
        snap();
        pkt = '{8'hD2};
        start_pkt(); send_bytes(); end_pkt();
        total++;
        if (hs_valid_o !== 1'b1 || pid_o !== 4'h2) $display("FAIL ack: got hs=%b pid=%h required 1/2", hs_valid_o, pid_o);
        else passed++;
        settle();
        snap();
        pkt = '{8'hD3};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_pe - s_pe != 1 || (n_hs - s_hs) + (n_seq - s_seq) + (n_done - s_done) + (n_tok - s_tok) != 0)
            $display("FAIL bad_pid: got pid_err=%0d others=%0d required 1/0", n_pe - s_pe,
                     (n_hs - s_hs) + (n_seq - s_seq) + (n_done - s_done) + (n_tok - s_tok));
        else passed++;
        snap();
        pkt = '{8'hD2, 8'h00};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_seq - s_seq != 1 || n_hs - s_hs != 0)
            $display("FAIL ack_long: got seq=%0d hs=%0d required 1/0", n_seq - s_seq, n_hs - s_hs);
        else passed++;
    endtask

    task automatic test_crc5_err();
        snap();
        pkt = '{8'h2D, 8'h00, 8'h11};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_c5 - s_c5 != 1 || n_tok - s_tok != 0 || n_seq - s_seq != 0)
            $display("FAIL crc5_bad: got c5=%0d tok=%0d seq=%0d required 1/0/0", n_c5 - s_c5, n_tok - s_tok, n_seq - s_seq);
        else passed++;
        snap();
        pkt = '{8'h2D, 8'h00};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_seq - s_seq != 1 || n_tok - s_tok != 0)
            $display("FAIL tok_short: got seq=%0d tok=%0d required 1/0", n_seq - s_seq, n_tok - s_tok);
        else passed++;
    endtask

    task automatic test_abort();
        snap();
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00};
        start_pkt(); send_bytes();
        @(posedge clk); #1 rx_err_i = 1'b1;
        @(posedge clk); #1 rx_err_i = 1'b0;
        pkt = '{8'h01, 8'h00};
        send_bytes(); end_pkt(); settle();
        total++;
        if (n_seq - s_seq != 1 || n_done - s_done != 1 || n_done_err - s_done_err != 1)
            $display("FAIL abort: got seq=%0d done=%0d err=%0d required 1/1/1", n_seq - s_seq, n_done - s_done, n_done_err - s_done_err);
        else passed++;
        total++;
        if (n_dv - s_dv != 1) $display("FAIL abort_dv: got %0d required 1", n_dv - s_dv);
        else passed++;
    endtask

    task automatic test_reset_mid();
        snap();
        pkt = '{8'hC3, 8'h80, 8'h06};
        start_pkt(); send_bytes();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        pkt = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_bytes(); end_pkt(); settle();
        total++;
        if ((n_dv - s_dv) + (n_done - s_done) + (n_seq - s_seq) + (n_pe - s_pe) + (n_hs - s_hs) + (n_tok - s_tok) != 0)
            $display("FAIL reset_mid_quiet: got %0d pulses required 0",
                     (n_dv - s_dv) + (n_done - s_done) + (n_seq - s_seq) + (n_pe - s_pe) + (n_hs - s_hs) + (n_tok - s_tok));
        else passed++;
        snap();
        pkt = '{8'h2D, 8'h00, 8'h10};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_tok - s_tok != 1 || pid_o !== 4'hD)
            $display("FAIL reset_mid_recover: got tok=%0d pid=%h required 1/D", n_tok - s_tok, pid_o);
        else passed++;
    endtask

    task automatic test_sof();
        snap();
        pkt = '{8'hA5, 8'h01, 8'hE8};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_tok - s_tok != 0 || n_c5 - s_c5 != 0 || n_seq - s_seq != 0)
            $display("FAIL sof_good: got tok=%0d c5=%0d seq=%0d required 0/0/0", n_tok - s_tok, n_c5 - s_c5, n_seq - s_seq);
        else passed++;
`ifdef USB_RX_SOF_EN
        total++;
        if (n_sof - s_sof != 1 || last_frame !== 11'h001)
            $display("FAIL sof_frame: got sof=%0d frame=%h required 1/001", n_sof - s_sof, last_frame);
        else passed++;
`endif
        snap();
        pkt = '{8'hA5, 8'h01, 8'hE9};
        start_pkt(); send_bytes(); end_pkt(); settle();
        total++;
        if (n_c5 - s_c5 != 1 || n_sof - s_sof != 0 || n_tok - s_tok != 0)
            $display("FAIL sof_bad_crc: got c5=%0d sof=%0d tok=%0d required 1/0/0", n_c5 - s_c5, n_sof - s_sof, n_tok - s_tok);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_token();
        test_data();
        test_short_data();
        test_handshake();
        test_crc5_err();
        test_abort();
        test_reset_mid();
        test_sof();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
